// File: rtl/fp_pkg.sv
// Shared constants and types for the single-precision FP datapath blocks.
// Imported by the unpacker and the float-to-int converter.
package fp_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    // The one float that converts exactly to INT_MIN despite E==31
    localparam logic [31:0] FP_NEG_2_31 = 32'hCF00_0000;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
    localparam logic [1:0] ST_ROUND_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_SHIFT = ST_SHIFT_ENC,
        ST_ROUND = ST_ROUND_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_e;

    typedef enum logic [2:0] {
        CLS_ZERO   = 3'd0,
        CLS_DENORM = 3'd1,
        CLS_NORMAL = 3'd2,
        CLS_INF    = 3'd3,
        CLS_NAN    = 3'd4
    } fp_class_e;

endpackage

// File: rtl/fp_unpack.sv
// Combinational IEEE-754 single unpacker: fields, operand class and unbiased
// exponent. Shared between the adder and the float-to-int converter.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0]       src,
    output logic              sign,
    output logic [FRAC_W-1:0] frac,
    output fp_class_e         cls,
    output logic signed [9:0] e_unb
);

    logic [EXP_W-1:0] exp_f;

    always_comb begin
        sign  = src[31];
        exp_f = src[30:23];
        frac  = src[22:0];
        e_unb = $signed({2'b00, exp_f}) - 10'sd127;
        if (exp_f == 8'hFF) begin
            cls = (frac != '0) ? CLS_NAN : CLS_INF;
        end else if (exp_f == 8'h00) begin
            cls = (frac != '0) ? CLS_DENORM : CLS_ZERO;
        end else begin
            cls = CLS_NORMAL;
        end
    end

endmodule

// File: rtl/fp_to_int_seq.sv
// Multi-cycle IEEE-754 single to signed int32 converter on a valid/ready stream.
// Denormalises one bit per cycle, then rounds with guard/round/sticky bits.
module fp_to_int_seq
    import fp_pkg::*;
#(
    parameter int ROUND_MODE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] src,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic        invalid,
    output logic        inexact
);

    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // result and its flags are held stable while out_valid && !out_ready.

    logic              u_sign;
    logic [FRAC_W-1:0] u_frac;
    fp_class_e         u_cls;
    logic signed [9:0] u_e;

    fp_unpack u_unpack (
        .src   (src),
        .sign  (u_sign),
        .frac  (u_frac),
        .cls   (u_cls),
        .e_unb (u_e)
    );

    state_e      state_q, state_d;
    logic        sign_q, sign_d;
    logic        left_q, left_d;
    logic [31:0] m_q, m_d;
    logic [4:0]  n_q, n_d;
    logic        g_q, g_d, r_q, r_d, s_q, s_d;
    logic [31:0] out_q, out_d;
    logic        invalid_q, invalid_d;
    logic        inexact_q, inexact_d;
    logic        out_valid_q, out_valid_d;

    logic        inc;
    logic [31:0] mag;

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        left_d      = left_q;
        m_d         = m_q;
        n_d         = n_q;
        g_d         = g_q;
        r_d         = r_q;
        s_d         = s_q;
        out_d       = out_q;
        invalid_d   = invalid_q;
        inexact_d   = inexact_q;
        out_valid_d = out_valid_q;
        inc         = 1'b0;
        mag         = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d    = u_sign;
                    m_d       = {8'b0, 1'b1, u_frac};
                    n_d       = '0;
                    left_d    = 1'b0;
                    g_d       = 1'b0;
                    r_d       = 1'b0;
                    s_d       = 1'b0;
                    out_d     = '0;
                    invalid_d = 1'b0;
                    inexact_d = 1'b0;
                    if (u_cls == CLS_NAN) begin
                        out_d       = INT_MAX;
                        invalid_d   = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else if (u_cls == CLS_INF) begin
                        out_d       = u_sign ? INT_MIN : INT_MAX;
                        invalid_d   = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else if (u_e >= 10'sd31) begin
                        out_d       = u_sign ? INT_MIN : INT_MAX;
                        invalid_d   = (src != FP_NEG_2_31);
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else if (u_cls == CLS_ZERO || u_cls == CLS_DENORM) begin
                        inexact_d   = (u_frac != '0);
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else if (u_e <= -10'sd2) begin
                        inexact_d   = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else if (u_e <= 10'sd22) begin
                        // Low five bits suffice: the shift count is always 1..24
                        n_d     = 5'd23 - u_e[4:0];
                        state_d = ST_SHIFT;
                    end else begin
                        left_d  = 1'b1;
                        n_d     = u_e[4:0] - 5'd23;
                        state_d = (u_e == 10'sd23) ? ST_ROUND : ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (left_q) begin
                    m_d = m_q << 1;
                end else begin
                    m_d = m_q >> 1;
                    g_d = m_q[0];
                    r_d = g_q;
                    s_d = s_q | r_q;
                end
                n_d = n_q - 5'd1;
                if (n_q == 5'd1) begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                inc         = (ROUND_MODE == 0) && g_q && (r_q || s_q || m_q[0]);
                mag         = m_q + {31'b0, inc};
                out_d       = sign_q ? (32'd0 - mag) : mag;
                inexact_d   = g_q | r_q | s_q;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sign_q      <= 1'b0;
            left_q      <= 1'b0;
            m_q         <= '0;
            n_q         <= '0;
            g_q         <= 1'b0;
            r_q         <= 1'b0;
            s_q         <= 1'b0;
            out_q       <= '0;
            invalid_q   <= 1'b0;
            inexact_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            left_q      <= left_d;
            m_q         <= m_d;
            n_q         <= n_d;
            g_q         <= g_d;
            r_q         <= r_d;
            s_q         <= s_d;
            out_q       <= out_d;
            invalid_q   <= invalid_d;
            inexact_q   <= inexact_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign invalid   = invalid_q;
    assign inexact   = inexact_q;

endmodule

// File: tb/tb_fp_to_int_seq.sv
// Directed bench for fp_to_int_seq: vector table run through an RNE and an
// RTZ instance side by side, plus backpressure and mid-operation reset.
module tb_fp_to_int_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] src = '0;
    logic        out_ready = 1'b1;

    logic        in_ready0, out_valid0, invalid0, inexact0;
    logic [31:0] out0;
    logic        in_ready1, out_valid1, invalid1, inexact1;
    logic [31:0] out1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_to_int_seq #(.ROUND_MODE(0)) dut_rne (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .src       (src),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out       (out0),
        .invalid   (invalid0),
        .inexact   (inexact0)
    );

    fp_to_int_seq #(.ROUND_MODE(1)) dut_rtz (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .src       (src),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out       (out1),
        .invalid   (invalid1),
        .inexact   (inexact1)
    );

    typedef struct {
        logic [31:0] src;
        logic [31:0] exp_rne;
        logic [31:0] exp_rtz;
        logic        exp_inv;
        logic        exp_inx;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Presents one operand, counts edges until out_valid, returns latency.
    task automatic send(input logic [31:0] v, output int lat);
        @(negedge clk);
        chk("in_ready_before_send", {31'b0, in_ready0}, 32'd1);
        src      = v;
        in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        in_valid = 1'b0;
        while (!out_valid0 && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        string tag;
        send(v.src, lat);
        tag = $sformatf("%08h", v.src);
        chk({"lat_", tag}, lat, v.exp_lat);
        chk({"out_rne_", tag}, out0, v.exp_rne);
        chk({"inv_rne_", tag}, {31'b0, invalid0}, {31'b0, v.exp_inv});
        chk({"inx_rne_", tag}, {31'b0, inexact0}, {31'b0, v.exp_inx});
        chk({"ov_rtz_", tag}, {31'b0, out_valid1}, 32'd1);
        chk({"out_rtz_", tag}, out1, v.exp_rtz);
        chk({"inv_rtz_", tag}, {31'b0, invalid1}, {31'b0, v.exp_inv});
        chk({"inx_rtz_", tag}, {31'b0, inexact1}, {31'b0, v.exp_inx});
        // out_ready is high: the next edge drains DONE back to IDLE
        @(posedge clk);
        #1;
        chk({"ov_drop_", tag}, {31'b0, out_valid0}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] held;

        //            src           rne           rtz           inv   inx   lat
        vecs.push_back('{32'h40490FDB, 32'd3,        32'd3,        1'b0, 1'b1, 24});
        vecs.push_back('{32'h3F000000, 32'd0,        32'd0,        1'b0, 1'b1, 26});
        vecs.push_back('{32'h3FC00000, 32'd2,        32'd1,        1'b0, 1'b1, 25});
        vecs.push_back('{32'h40200000, 32'd2,        32'd2,        1'b0, 1'b1, 24});
        vecs.push_back('{32'h3F400000, 32'd1,        32'd0,        1'b0, 1'b1, 26});
        vecs.push_back('{32'hBFC00000, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 1'b1, 25});
        vecs.push_back('{32'h7F800000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, 1});
        vecs.push_back('{32'hFF800000, 32'h80000000, 32'h80000000, 1'b1, 1'b0, 1});
        vecs.push_back('{32'h7FC00000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, 1});
        vecs.push_back('{32'h4F000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, 1});
        vecs.push_back('{32'hCF000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1});
        vecs.push_back('{32'h00000001, 32'd0,        32'd0,        1'b0, 1'b1, 1});
        vecs.push_back('{32'h4B000001, 32'h00800001, 32'h00800001, 1'b0, 1'b0, 2});
        vecs.push_back('{32'h4EFFFFFF, 32'h7FFFFF80, 32'h7FFFFF80, 1'b0, 1'b0, 9});
        vecs.push_back('{32'h80000000, 32'd0,        32'd0,        1'b0, 1'b0, 1});
        vecs.push_back('{32'h3E800000, 32'd0,        32'd0,        1'b0, 1'b1, 1});
        vecs.push_back('{32'hC0200000, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 1'b1, 24});
        vecs.push_back('{32'h41200000, 32'd10,       32'd10,       1'b0, 1'b0, 22});
        vecs.push_back('{32'hC2F60000, 32'hFFFFFF85, 32'hFFFFFF85, 1'b0, 1'b0, 19});
        vecs.push_back('{32'h3FE00000, 32'd2,        32'd1,        1'b0, 1'b1, 25});
        vecs.push_back('{32'h40600000, 32'd4,        32'd3,        1'b0, 1'b1, 24});

        // Reset values, checked while rst_n is still low and in_valid is high
        src      = 32'h3FC00000;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready0}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid0}, 32'd0);
        chk("rst_out", out0, 32'd0);
        chk("rst_flags", {30'b0, invalid0, inexact0}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: result and flags must hold, no new operand accepted
        out_ready = 1'b0;
        send(32'h40490FDB, lat);
        chk("bp_lat", lat, 24);
        held = out0;
        chk("bp_out", held, 32'd3);
        @(negedge clk);
        src      = 32'h7F800000;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_out", out0, 32'd3);
            chk("bp_hold_flags", {30'b0, invalid0, inexact0}, 32'd1);
            chk("bp_hold_valid", {31'b0, out_valid0}, 32'd1);
            chk("bp_in_ready", {31'b0, in_ready0}, 32'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", {31'b0, out_valid0}, 32'd0);
        chk("bp_release_ready", {31'b0, in_ready0}, 32'd1);

        // Asynchronous reset in the middle of a 22-step shift
        @(negedge clk);
        src      = 32'h40490FDB;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_in_ready_busy", {31'b0, in_ready0}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", {31'b0, in_ready0}, 32'd1);
        chk("mid_rst_out_valid", {31'b0, out_valid0}, 32'd0);
        chk("mid_rst_out", out0, 32'd0);
        repeat (30) @(posedge clk);
        #1;
        chk("mid_rst_no_output", {31'b0, out_valid0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec('{32'hBFC00000, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 1'b1, 25});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
